sad_array: RTL and testbench

SAD_ARRAY -- requirements
Module: sad_array

---
 rtl/fsbm_pkg.sv | 20 ++
 rtl/sad_pe.sv | 49 ++++
 rtl/sad_array.sv | 189 ++++++++++++++++++
 tb/tb_sad_array.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsbm_pkg.sv
// Shared constants and state encoding for the full-search block-matching datapath
// (SAD array and downstream minimum-compare stage).
package fsbm_pkg;

    localparam int PIX_W   = 8;
    localparam int SUM_W   = 12;
    localparam int N_CAND  = 16;
    localparam int BLK_PIX = 16;
    localparam int CNT_W   = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Sample index of the final pixel of a block.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_PIX - 1);

endpackage

// File: rtl/sad_pe.sv
// One SAD processing element: absolute difference of a pixel pair plus a
// clearable, enabled accumulator. o_next is the accumulator value including this pair.
module sad_pe #(
    parameter int PIX_W = fsbm_pkg::PIX_W,
    parameter int SUM_W = fsbm_pkg::SUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_cur,
    input  logic [PIX_W-1:0] i_ref,
    output logic [SUM_W-1:0] o_next
);

    logic [SUM_W-1:0] r_acc;
    logic [PIX_W-1:0] w_absdiff;

    // One extra bit keeps the signed difference exact; its magnitude always fits PIX_W.
    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        logic signed [PIX_W:0] d;
        logic signed [PIX_W:0] m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d[PIX_W]) begin
            m = -d;
        end else begin
            m = d;
        end
        return m[PIX_W-1:0];
    endfunction

    assign w_absdiff = abs_diff(i_cur, i_ref);
    assign o_next    = r_acc + {{(SUM_W - PIX_W){1'b0}}, w_absdiff};

    // Accumulator: cleared at block start, advanced on each accepted sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= {SUM_W{1'b0}};
        end else if (i_clear) begin
            r_acc <= {SUM_W{1'b0}};
        end else if (i_en) begin
            r_acc <= o_next;
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/sad_array.sv
// Sixteen-candidate SAD engine for a 4x4 block: control FSM, sample counter,
// parallel PEs and registered result bank.
module sad_array #(
    parameter int PIX_W   = fsbm_pkg::PIX_W,
    parameter int SUM_W   = fsbm_pkg::SUM_W,
    parameter int N_CAND  = fsbm_pkg::N_CAND,
    parameter int BLK_PIX = fsbm_pkg::BLK_PIX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] cur_pix,
    input  logic [PIX_W-1:0] ref_pix0,
    input  logic [PIX_W-1:0] ref_pix1,
    input  logic [PIX_W-1:0] ref_pix2,
    input  logic [PIX_W-1:0] ref_pix3,
    input  logic [PIX_W-1:0] ref_pix4,
    input  logic [PIX_W-1:0] ref_pix5,
    input  logic [PIX_W-1:0] ref_pix6,
    input  logic [PIX_W-1:0] ref_pix7,
    input  logic [PIX_W-1:0] ref_pix8,
    input  logic [PIX_W-1:0] ref_pix9,
    input  logic [PIX_W-1:0] ref_pix10,
    input  logic [PIX_W-1:0] ref_pix11,
    input  logic [PIX_W-1:0] ref_pix12,
    input  logic [PIX_W-1:0] ref_pix13,
    input  logic [PIX_W-1:0] ref_pix14,
    input  logic [PIX_W-1:0] ref_pix15,
    output logic [SUM_W-1:0] sum0,
    output logic [SUM_W-1:0] sum1,
    output logic [SUM_W-1:0] sum2,
    output logic [SUM_W-1:0] sum3,
    output logic [SUM_W-1:0] sum4,
    output logic [SUM_W-1:0] sum5,
    output logic [SUM_W-1:0] sum6,
    output logic [SUM_W-1:0] sum7,
    output logic [SUM_W-1:0] sum8,
    output logic [SUM_W-1:0] sum9,
    output logic [SUM_W-1:0] sum10,
    output logic [SUM_W-1:0] sum11,
    output logic [SUM_W-1:0] sum12,
    output logic [SUM_W-1:0] sum13,
    output logic [SUM_W-1:0] sum14,
    output logic [SUM_W-1:0] sum15,
    output logic             busy,
    output logic             done
);
    import fsbm_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_clear;
    logic             w_en;
    logic             w_last;
    logic [PIX_W-1:0] w_ref  [N_CAND];
    logic [SUM_W-1:0] w_next [N_CAND];
    logic [SUM_W-1:0] r_sum  [N_CAND];

    assign w_ref[0]  = ref_pix0;
    assign w_ref[1]  = ref_pix1;
    assign w_ref[2]  = ref_pix2;
    assign w_ref[3]  = ref_pix3;
    assign w_ref[4]  = ref_pix4;
    assign w_ref[5]  = ref_pix5;
    assign w_ref[6]  = ref_pix6;
    assign w_ref[7]  = ref_pix7;
    assign w_ref[8]  = ref_pix8;
    assign w_ref[9]  = ref_pix9;
    assign w_ref[10] = ref_pix10;
    assign w_ref[11] = ref_pix11;
    assign w_ref[12] = ref_pix12;
    assign w_ref[13] = ref_pix13;
    assign w_ref[14] = ref_pix14;
    assign w_ref[15] = ref_pix15;

    // Next-state and datapath strobes; start and pix_valid only matter in their own state.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_en        = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (pix_valid) begin
                    w_en = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, sample counter and status flags, with flags registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_ACCUM);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_clear) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (w_en) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    for (genvar g = 0; g < N_CAND; g++) begin : g_pe
        sad_pe #(
            .PIX_W (PIX_W),
            .SUM_W (SUM_W)
        ) u_pe (
            .clk     (clk),
            .rst     (rst),
            .i_clear (w_clear),
            .i_en    (w_en),
            .i_cur   (cur_pix),
            .i_ref   (w_ref[g]),
            .o_next  (w_next[g])
        );
    end

    // Result bank captures the completed sums and holds them until the next block ends.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CAND; i++) begin
                r_sum[i] <= {SUM_W{1'b0}};
            end
        end else if (w_last) begin
            for (int i = 0; i < N_CAND; i++) begin
                r_sum[i] <= w_next[i];
            end
        end else begin
            for (int i = 0; i < N_CAND; i++) begin
                r_sum[i] <= r_sum[i];
            end
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sum0  = r_sum[0];
    assign sum1  = r_sum[1];
    assign sum2  = r_sum[2];
    assign sum3  = r_sum[3];
    assign sum4  = r_sum[4];
    assign sum5  = r_sum[5];
    assign sum6  = r_sum[6];
    assign sum7  = r_sum[7];
    assign sum8  = r_sum[8];
    assign sum9  = r_sum[9];
    assign sum10 = r_sum[10];
    assign sum11 = r_sum[11];
    assign sum12 = r_sum[12];
    assign sum13 = r_sum[13];
    assign sum14 = r_sum[14];
    assign sum15 = r_sum[15];

endmodule

// File: tb/tb_sad_array.sv
// Randomized scoreboard bench for sad_array: the driver pushes reference sums
// computed by plain arithmetic, the monitor pops them on every done pulse.
module tb_sad_array;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pix_valid;
    logic [7:0]  cur_pix;
    logic [7:0]  ref_pix [16];
    logic [11:0] sum     [16];
    logic        busy;
    logic        done;

    int n_checks;
    int n_errors;

    logic [15:0][11:0] exp_q [$];
    logic [15:0][11:0] mon_exp;

    sad_array dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pix_valid (pix_valid),
        .cur_pix   (cur_pix),
        .ref_pix0  (ref_pix[0]),
        .ref_pix1  (ref_pix[1]),
        .ref_pix2  (ref_pix[2]),
        .ref_pix3  (ref_pix[3]),
        .ref_pix4  (ref_pix[4]),
        .ref_pix5  (ref_pix[5]),
        .ref_pix6  (ref_pix[6]),
        .ref_pix7  (ref_pix[7]),
        .ref_pix8  (ref_pix[8]),
        .ref_pix9  (ref_pix[9]),
        .ref_pix10 (ref_pix[10]),
        .ref_pix11 (ref_pix[11]),
        .ref_pix12 (ref_pix[12]),
        .ref_pix13 (ref_pix[13]),
        .ref_pix14 (ref_pix[14]),
        .ref_pix15 (ref_pix[15]),
        .sum0      (sum[0]),
        .sum1      (sum[1]),
        .sum2      (sum[2]),
        .sum3      (sum[3]),
        .sum4      (sum[4]),
        .sum5      (sum[5]),
        .sum6      (sum[6]),
        .sum7      (sum[7]),
        .sum8      (sum[8]),
        .sum9      (sum[9]),
        .sum10     (sum[10]),
        .sum11     (sum[11]),
        .sum12     (sum[12]),
        .sum13     (sum[13]),
        .sum14     (sum[14]),
        .sum15     (sum[15]),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        cur_pix = 8'($urandom_range(255));
        for (int i = 0; i < 16; i++) ref_pix[i] = 8'($urandom_range(255));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL done_unexpected: got done=1 expected no done at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                for (int i = 0; i < 16; i++) begin
                    n_checks++;
                    if (sum[i] !== mon_exp[i]) begin
                        n_errors++;
                        $display("FAIL sum%0d: got %0d expected %0d at %0t",
                                 i, sum[i], mon_exp[i], $time);
                    end
                end
            end
        end
    end

    // mode: 0 ref=cur, 1 cur=255/ref=0, 2 ref=100+k, 3 ref=100-k, 4 random.
    // gmode: 0 no gaps, 1 two idle cycles after each sample, 2 random gaps.
    task automatic run_block(input int mode, input int gmode,
                             input bit mid_start, input bit done_start);
        int                acc [16];
        int                d;
        int                ngap;
        logic [15:0][11:0] e;
        for (int i = 0; i < 16; i++) acc[i] = 0;
        // start cycle carries valid-looking data that must be ignored
        start = 1'b1;
        pix_valid = 1'b1;
        junk_inputs();
        tick();
        start = 1'b0;
        for (int s = 0; s < 16; s++) begin
            chk("busy_accum", int'(busy), 1);
            if (s > 0) begin
                ngap = (gmode == 1) ? 2 : (gmode == 2) ? int'($urandom_range(3)) : 0;
                for (int g = 0; g < ngap; g++) begin
                    pix_valid = 1'b0;
                    junk_inputs();
                    tick();
                    chk("busy_gap", int'(busy), 1);
                end
            end
            case (mode)
                0: begin
                    cur_pix = 8'($urandom_range(255));
                    for (int k = 0; k < 16; k++) ref_pix[k] = cur_pix;
                end
                1: begin
                    cur_pix = 8'd255;
                    for (int k = 0; k < 16; k++) ref_pix[k] = 8'd0;
                end
                2: begin
                    cur_pix = 8'd100;
                    for (int k = 0; k < 16; k++) ref_pix[k] = 8'(100 + k);
                end
                3: begin
                    cur_pix = 8'd100;
                    for (int k = 0; k < 16; k++) ref_pix[k] = 8'(100 - k);
                end
                default: junk_inputs();
            endcase
            for (int k = 0; k < 16; k++) begin
                d = int'(cur_pix) - int'(ref_pix[k]);
                acc[k] += (d < 0) ? -d : d;
            end
            pix_valid = 1'b1;
            start = (mid_start && s == 5) ? 1'b1 : 1'b0;
            if (s == 15) begin
                for (int k = 0; k < 16; k++) e[k] = 12'(acc[k]);
                exp_q.push_back(e);
            end
            tick();
        end
        start = done_start;
        pix_valid = 1'b1;
        junk_inputs();
        chk("done_latency", int'(done), 1);
        chk("busy_in_done", int'(busy), 0);
        tick();
        start = 1'b0;
        pix_valid = 1'b0;
        chk("done_pulse_end", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
        tick();
        chk("idle_stays_idle", int'(busy), 0);
        chk("no_second_done", int'(done), 0);
        for (int k = 0; k < 16; k++) chk($sformatf("sum%0d_hold", k), int'(sum[k]), int'(e[k]));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        for (int k = 0; k < 16; k++) chk($sformatf("%s_sum%0d", tag, k), int'(sum[k]), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        start = 1'b0;
        pix_valid = 1'b0;
        junk_inputs();
        repeat (3) tick();
        rst = 1'b1;
        check_cleared("reset");
        tick();

        run_block(0, 0, 1'b0, 1'b0);
        run_block(1, 0, 1'b0, 1'b0);
        run_block(2, 0, 1'b0, 1'b0);
        run_block(3, 0, 1'b0, 1'b0);
        run_block(2, 1, 1'b0, 1'b0);
        run_block(4, 2, 1'b1, 1'b1);
        run_block(4, 0, 1'b0, 1'b0);

        // Abort after eight samples; reset also overrides start/pix_valid.
        start = 1'b1;
        pix_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int s = 0; s < 8; s++) begin
            pix_valid = 1'b1;
            junk_inputs();
            tick();
        end
        rst = 1'b0;
        start = 1'b1;
        pix_valid = 1'b1;
        tick();
        rst = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        check_cleared("abort");
        tick();
        chk("abort_idle", int'(busy), 0);
        run_block(4, 0, 1'b0, 1'b0);

        for (int b = 0; b < 5; b++) begin
            run_block(int'($urandom_range(4)), int'($urandom_range(2)),
                      1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        repeat (3) tick();
        chk("pending_results", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
